// File: rtl/stall_ctrl_if.sv
// stall_ctrl_if: bundle of pipeline-side signals exchanged with the stall
// controller / mult-div sequencer.
//   slave  modport : the stall_ctrl block (hazard inputs in, enables/HI/LO out)
//   master modport : the pipeline that drives D/E/M stage info and consumes
//                    F_En, D_En, E_Flush, Busy, HI, LO
interface stall_ctrl_if;
    // D-stage operand demand
    logic [4:0]  D_RS_Addr;
    logic [4:0]  D_RT_Addr;
    logic [1:0]  D_RS_Tuse;
    logic [1:0]  D_RT_Tuse;
    logic        D_IsMD;
    // E/M-stage result readiness
    logic [4:0]  E_RegAddr;
    logic [4:0]  M_RegAddr;
    logic [2:0]  E_Tnew;
    logic [2:0]  M_Tnew;
    // E-stage mult/div control and operands
    logic        E_MDStart;
    logic [1:0]  E_MDOp;
    logic        E_MTHI;
    logic        E_MTLO;
    logic [31:0] E_RS_Data;
    logic [31:0] E_RT_Data;
    // Outputs of the controller
    logic        F_En;
    logic        D_En;
    logic        E_Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport slave (
        input  D_RS_Addr, D_RT_Addr, D_RS_Tuse, D_RT_Tuse, D_IsMD,
        input  E_RegAddr, M_RegAddr, E_Tnew, M_Tnew,
        input  E_MDStart, E_MDOp, E_MTHI, E_MTLO, E_RS_Data, E_RT_Data,
        output F_En, D_En, E_Flush, Busy, HI, LO
    );

    modport master (
        output D_RS_Addr, D_RT_Addr, D_RS_Tuse, D_RT_Tuse, D_IsMD,
        output E_RegAddr, M_RegAddr, E_Tnew, M_Tnew,
        output E_MDStart, E_MDOp, E_MTHI, E_MTLO, E_RS_Data, E_RT_Data,
        input  F_En, D_En, E_Flush, Busy, HI, LO
    );
endinterface

// File: rtl/stall_ctrl.sv
// stall_ctrl: pipeline stall controller plus multi-cycle mult/div sequencer.
//   Clk    : rising-edge clock
//   Reset  : asynchronous, active-low reset
//   bus    : stall_ctrl_if.slave
//            - Tuse/Tnew hazard detection -> F_En, D_En, E_Flush (combinational)
//            - mult/multu/div/divu sequencing with HI/LO registers -> Busy, HI, LO
module stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic         Clk,
    input  logic         Reset,
    stall_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;

    logic        haz_rs, haz_rt, haz_md, stall, busy;

    // ---------------- hazard detection ----------------
    assign busy   = (state_q == RUN);
    assign haz_rs = (bus.D_RS_Addr != '0) &&
                    (((bus.D_RS_Addr == bus.E_RegAddr) && (bus.E_Tnew > {1'b0, bus.D_RS_Tuse})) ||
                     ((bus.D_RS_Addr == bus.M_RegAddr) && (bus.M_Tnew > {1'b0, bus.D_RS_Tuse})));
    assign haz_rt = (bus.D_RT_Addr != '0) &&
                    (((bus.D_RT_Addr == bus.E_RegAddr) && (bus.E_Tnew > {1'b0, bus.D_RT_Tuse})) ||
                     ((bus.D_RT_Addr == bus.M_RegAddr) && (bus.M_Tnew > {1'b0, bus.D_RT_Tuse})));
    assign haz_md = bus.D_IsMD && (busy || bus.E_MDStart);
    assign stall  = haz_rs || haz_rt || haz_md;

    assign bus.F_En    = !stall;
    assign bus.D_En    = !stall;
    assign bus.E_Flush = stall;
    assign bus.Busy    = busy;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;

    // ---------------- result datapath ----------------
    logic [63:0]        prod_s, prod_u;
    logic signed [31:0] quot_s, rem_s;
    logic [31:0]        quot_u, rem_u;
    logic               div_zero, div_ovf;
    logic [31:0]        res_hi, res_lo;

    assign prod_s   = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u   = {32'b0, a_q} * {32'b0, b_q};
    assign div_zero = (b_q == '0);
    // The one signed quotient that does not fit in 32 bits is forced explicitly.
    assign div_ovf  = (a_q == 32'h8000_0000) && (b_q == '1);

    always_comb begin
        quot_s = '0;
        rem_s  = '0;
        quot_u = '0;
        rem_u  = '0;
        if (!div_zero && !div_ovf) begin
            quot_s = $signed(a_q) / $signed(b_q);
            rem_s  = $signed(a_q) % $signed(b_q);
        end
        if (!div_zero) begin
            quot_u = a_q / b_q;
            rem_u  = a_q % b_q;
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op_q)
            2'b00: {res_hi, res_lo} = prod_s;
            2'b01: {res_hi, res_lo} = prod_u;
            2'b10: begin
                if (div_ovf) begin
                    res_hi = '0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = rem_s;
                    res_lo = quot_s;
                end
            end
            default: begin
                res_hi = rem_u;
                res_lo = quot_u;
            end
        endcase
    end

    // ---------------- mult/div sequencer ----------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.E_MDStart) begin
                        state_q <= RUN;
                        op_q    <= bus.E_MDOp;
                        a_q     <= bus.E_RS_Data;
                        b_q     <= bus.E_RT_Data;
                        cnt_q   <= bus.E_MDOp[1] ? DIV_CNT : MULT_CNT;
                    end else begin
                        if (bus.E_MTHI) hi_q <= bus.E_RS_Data;
                        if (bus.E_MTLO) lo_q <= bus.E_RS_Data;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                        // Divide by zero burns the full latency but leaves HI/LO alone.
                        if (!(op_q[1] && div_zero)) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: self-checking bench for stall_ctrl. A behavioural model
// (remaining-busy countdown, results computed with 64-bit integer arithmetic
// at start time) is compared against the DUT every cycle; directed scenarios
// add literal expectations.
module tb_stall_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic Clk = 1'b0;
    logic Reset;

    stall_ctrl_if bus_if();

    stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_if)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // model state
    int          md_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit haz(input logic [4:0] a, input logic [1:0] tuse);
        int tu;
        tu = int'(tuse);
        return (a != 5'd0) &&
               ((a == bus_if.E_RegAddr && int'(bus_if.E_Tnew) > tu) ||
                (a == bus_if.M_RegAddr && int'(bus_if.M_Tnew) > tu));
    endfunction

    task automatic model_reset();
        md_rem = 0;
        m_hi   = '0;
        m_lo   = '0;
        p_wr   = 1'b0;
    endtask

    task automatic model_edge();
        logic signed [63:0] sa, sb, r, q;
        logic [63:0] ua, ub, ur;
        if (Reset === 1'b0) return;
        if (md_rem > 0) begin
            md_rem--;
            if (md_rem == 0 && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (bus_if.E_MDStart) begin
            sa = {{32{bus_if.E_RS_Data[31]}}, bus_if.E_RS_Data};
            sb = {{32{bus_if.E_RT_Data[31]}}, bus_if.E_RT_Data};
            ua = {32'b0, bus_if.E_RS_Data};
            ub = {32'b0, bus_if.E_RT_Data};
            p_wr = 1'b1;
            case (bus_if.E_MDOp)
                2'd0: begin r = sa * sb; p_hi = r[63:32]; p_lo = r[31:0]; end
                2'd1: begin ur = ua * ub; p_hi = ur[63:32]; p_lo = ur[31:0]; end
                2'd2: begin
                    if (sb == 0) p_wr = 1'b0;
                    else begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
                end
                default: begin
                    if (ub == 0) p_wr = 1'b0;
                    else begin ur = ua / ub; p_lo = ur[31:0]; ur = ua % ub; p_hi = ur[31:0]; end
                end
            endcase
            md_rem = bus_if.E_MDOp[1] ? DIV_N : MULT_N;
        end else begin
            if (bus_if.E_MTHI) m_hi = bus_if.E_RS_Data;
            if (bus_if.E_MTLO) m_lo = bus_if.E_RS_Data;
        end
    endtask

    task automatic check_model();
        bit st;
        st = haz(bus_if.D_RS_Addr, bus_if.D_RS_Tuse) || haz(bus_if.D_RT_Addr, bus_if.D_RT_Tuse) ||
             (bus_if.D_IsMD && (md_rem > 0 || bus_if.E_MDStart));
        chk("m_F_En",    {31'b0, bus_if.F_En},    {31'b0, !st});
        chk("m_D_En",    {31'b0, bus_if.D_En},    {31'b0, !st});
        chk("m_E_Flush", {31'b0, bus_if.E_Flush}, {31'b0, st});
        chk("m_Busy",    {31'b0, bus_if.Busy},    {31'b0, md_rem > 0});
        chk("m_HI", bus_if.HI, m_hi);
        chk("m_LO", bus_if.LO, m_lo);
    endtask

    task automatic cycle();
        #1;
        check_model();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.D_RS_Addr = '0; bus_if.D_RT_Addr = '0;
        bus_if.D_RS_Tuse = 2'd3; bus_if.D_RT_Tuse = 2'd3;
        bus_if.D_IsMD = 1'b0;
        bus_if.E_RegAddr = '0; bus_if.M_RegAddr = '0;
        bus_if.E_Tnew = '0; bus_if.M_Tnew = '0;
        bus_if.E_MDStart = 1'b0; bus_if.E_MDOp = '0;
        bus_if.E_MTHI = 1'b0; bus_if.E_MTLO = 1'b0;
        bus_if.E_RS_Data = '0; bus_if.E_RT_Data = '0;
    endtask

    // Start one op, then count Busy cycles and stall cycles (start cycle included).
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic is_md, output int nbusy, output int nstall);
        bus_if.E_MDStart = 1'b1;
        bus_if.E_MDOp    = op;
        bus_if.E_RS_Data = a;
        bus_if.E_RT_Data = b;
        bus_if.D_IsMD    = is_md;
        #1;
        nstall = bus_if.F_En ? 0 : 1;
        cycle();
        bus_if.E_MDStart = 1'b0;
        nbusy = 0;
        forever begin
            #1;
            if (bus_if.Busy !== 1'b1 || nbusy >= 40) break;
            nbusy++;
            if (!bus_if.F_En) nstall++;
            cycle();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, ns;
        clear_inputs();
        Reset = 1'b0;
        model_reset();
        #6;
        chk("rst_Busy", {31'b0, bus_if.Busy}, 32'd0);
        chk("rst_HI", bus_if.HI, 32'h0);
        chk("rst_LO", bus_if.LO, 32'h0);
        cycle();
        cycle();
        Reset = 1'b1;
        cycle();

        // load-use hazard from E, resolved once the load is in M
        bus_if.E_RegAddr = 5'd1; bus_if.E_Tnew = 3'd2;
        bus_if.D_RS_Addr = 5'd1; bus_if.D_RS_Tuse = 2'd1;
        #1;
        chk("lu_F_En", {31'b0, bus_if.F_En}, 32'd0);
        chk("lu_E_Flush", {31'b0, bus_if.E_Flush}, 32'd1);
        cycle();
        bus_if.E_RegAddr = 5'd0; bus_if.E_Tnew = 3'd0;
        bus_if.M_RegAddr = 5'd1; bus_if.M_Tnew = 3'd1;
        #1;
        chk("lu_release", {31'b0, bus_if.F_En}, 32'd1);
        cycle();
        // $0 never hazards; Tuse=3 never hazards
        clear_inputs();
        bus_if.D_RS_Addr = 5'd0; bus_if.D_RS_Tuse = 2'd0;
        bus_if.E_RegAddr = 5'd0; bus_if.E_Tnew = 3'd2;
        #1;
        chk("zero_reg", {31'b0, bus_if.F_En}, 32'd1);
        cycle();
        bus_if.D_RT_Addr = 5'd5; bus_if.D_RT_Tuse = 2'd3;
        bus_if.E_RegAddr = 5'd5; bus_if.E_Tnew = 3'd2;
        #1;
        chk("tuse3", {31'b0, bus_if.F_En}, 32'd1);
        cycle();
        clear_inputs();

        run_md(2'd0, 32'hFFFF_FFFF, 32'h2, 1'b0, nb, ns);
        chk("mult_busy", 32'(nb), 32'd5);
        chk("mult_HI", bus_if.HI, 32'hFFFF_FFFF);
        chk("mult_LO", bus_if.LO, 32'hFFFF_FFFE);
        run_md(2'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, nb, ns);
        chk("multu_busy", 32'(nb), 32'd5);
        chk("multu_HI", bus_if.HI, 32'h1);
        chk("multu_LO", bus_if.LO, 32'hFFFF_FFFE);
        run_md(2'd2, 32'hFFFF_FFF9, 32'h2, 1'b0, nb, ns);
        chk("div_busy", 32'(nb), 32'd10);
        chk("div_HI", bus_if.HI, 32'hFFFF_FFFF);
        chk("div_LO", bus_if.LO, 32'hFFFF_FFFD);
        run_md(2'd3, 32'h7, 32'h0, 1'b0, nb, ns);
        chk("divz_busy", 32'(nb), 32'd10);
        chk("divz_HI", bus_if.HI, 32'hFFFF_FFFF);
        chk("divz_LO", bus_if.LO, 32'hFFFF_FFFD);
        run_md(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, ns);
        chk("ovf_HI", bus_if.HI, 32'h0);
        chk("ovf_LO", bus_if.LO, 32'h8000_0000);
        run_md(2'd0, 32'd3, 32'd4, 1'b1, nb, ns);
        chk("mflo_stall", 32'(ns), 32'd6);
        chk("mflo_release", {31'b0, bus_if.F_En}, 32'd1);
        chk("mflo_LO", bus_if.LO, 32'd12);
        bus_if.D_IsMD = 1'b0;

        // mthi/mtlo in IDLE, then start wins over a simultaneous mthi
        bus_if.E_MTHI = 1'b1; bus_if.E_RS_Data = 32'h1234_5678;
        cycle();
        chk("mthi", bus_if.HI, 32'h1234_5678);
        bus_if.E_MTHI = 1'b0; bus_if.E_MTLO = 1'b1; bus_if.E_RS_Data = 32'hCAFE_0001;
        cycle();
        chk("mtlo", bus_if.LO, 32'hCAFE_0001);
        bus_if.E_MTLO = 1'b0; bus_if.E_MTHI = 1'b1;
        run_md(2'd1, 32'd2, 32'd3, 1'b0, nb, ns);
        chk("prio_HI", bus_if.HI, 32'h0);
        chk("prio_LO", bus_if.LO, 32'd6);
        bus_if.E_MTHI = 1'b0;

        // reset in cycle 3 of a div aborts it
        bus_if.E_MDStart = 1'b1; bus_if.E_MDOp = 2'd2;
        bus_if.E_RS_Data = 32'd100; bus_if.E_RT_Data = 32'd7;
        cycle();
        bus_if.E_MDStart = 1'b0;
        cycle();
        cycle();
        Reset = 1'b0;
        model_reset();
        #1;
        chk("midrst_Busy", {31'b0, bus_if.Busy}, 32'd0);
        chk("midrst_HI", bus_if.HI, 32'h0);
        chk("midrst_LO", bus_if.LO, 32'h0);
        cycle();
        Reset = 1'b1;
        cycle();
        run_md(2'd0, 32'd3, 32'd5, 1'b0, nb, ns);
        chk("postrst_busy", 32'(nb), 32'd5);
        chk("postrst_LO", bus_if.LO, 32'd15);

        // randomized phase
        for (int i = 0; i < 2500; i++) begin
            bus_if.D_RS_Addr = 5'($urandom_range(0, 3));
            bus_if.D_RT_Addr = 5'($urandom_range(0, 3));
            bus_if.D_RS_Tuse = 2'($urandom_range(0, 3));
            bus_if.D_RT_Tuse = 2'($urandom_range(0, 3));
            bus_if.E_RegAddr = 5'($urandom_range(0, 3));
            bus_if.M_RegAddr = 5'($urandom_range(0, 3));
            bus_if.E_Tnew    = 3'($urandom_range(0, 2));
            bus_if.M_Tnew    = 3'($urandom_range(0, 2));
            bus_if.D_IsMD    = ($urandom_range(0, 3) == 0);
            bus_if.E_MDStart = ($urandom_range(0, 5) == 0);
            bus_if.E_MDOp    = 2'($urandom_range(0, 3));
            bus_if.E_MTHI    = ($urandom_range(0, 4) == 0);
            bus_if.E_MTLO    = ($urandom_range(0, 4) == 0);
            bus_if.E_RS_Data = pick();
            bus_if.E_RT_Data = pick();
            if (Reset == 1'b0) begin
                if ($urandom_range(0, 1) == 0) Reset = 1'b1;
            end else if ($urandom_range(0, 149) == 0) begin
                Reset = 1'b0;
                model_reset();
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
